hamming74_serial_rx: RTL and testbench

Serial receiver and decoder for the Hamming(7,4) link. It deserializes 7-bit codewords arriving LSB-first from the transmit-side shift register, then computes the 3-bit syndrome and corrects any single-bit error. The 4-bit data word is presented on a valid/ready output with error status. It sits at the far end of the serial channel, opposite the encoder plus parallel-to-serial shifter.

---
 rtl/hamming_pkg.sv | 36 +++
 rtl/hamming74_correct.sv | 27 ++
 rtl/hamming74_serial_rx.sv | 119 +++++++++++
 tb/tb_hamming74_serial_rx.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hamming_pkg.sv
// Shared Hamming(7,4) definitions: widths, codeword bit positions, receiver
// FSM states and the syndrome/extract helpers used by the decoder.
package hamming_pkg;

    localparam int CODE_W = 7;
    localparam int DATA_W = 4;

    // Bit index within the received codeword (bit k is position k+1).
    localparam int P1_IDX = 0;
    localparam int P2_IDX = 1;
    localparam int D1_IDX = 2;
    localparam int P3_IDX = 3;
    localparam int D2_IDX = 4;
    localparam int D3_IDX = 5;
    localparam int D4_IDX = 6;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DECODE
    } rx_state_t;

    // {s3,s2,s1}: the 1-based position of a single flipped bit, 0 when clean.
    function automatic logic [2:0] hamming_syndrome(input logic [CODE_W-1:0] cw);
        logic s1, s2, s3;
        s1 = cw[P1_IDX] ^ cw[D1_IDX] ^ cw[D2_IDX] ^ cw[D4_IDX];
        s2 = cw[P2_IDX] ^ cw[D1_IDX] ^ cw[D3_IDX] ^ cw[D4_IDX];
        s3 = cw[P3_IDX] ^ cw[D2_IDX] ^ cw[D3_IDX] ^ cw[D4_IDX];
        return {s3, s2, s1};
    endfunction

    function automatic logic [DATA_W-1:0] hamming_extract(input logic [CODE_W-1:0] cw);
        return {cw[D4_IDX], cw[D3_IDX], cw[D2_IDX], cw[D1_IDX]};
    endfunction

endpackage

// File: rtl/hamming74_correct.sv
// Combinational Hamming(7,4) syndrome and single-bit corrector; also used
// standalone by the encoder side for its self-check.
module hamming74_correct
    import hamming_pkg::*;
#(
    parameter int CORRECT = 1
) (
    input  logic [6:0] codeword,
    output logic [3:0] data,
    output logic [2:0] syndrome
);

    logic [6:0] fixed;

    assign syndrome = hamming_syndrome(codeword);

    // Flipping a parity position is harmless: extract ignores those bits.
    always_comb begin
        fixed = codeword;
        if (CORRECT != 0 && syndrome != 3'd0) begin
            fixed[syndrome - 3'd1] = ~codeword[syndrome - 3'd1];
        end
    end

    assign data = hamming_extract(fixed);

endmodule

// File: rtl/hamming74_serial_rx.sv
// Serial Hamming(7,4) receiver: LSB-first deserializer, one-cycle decode and
// a single-entry valid/ready output register with overrun/abort pulses.
module hamming74_serial_rx
    import hamming_pkg::*;
#(
    parameter int CORRECT = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       serial_in,
    input  logic       bit_valid,
    input  logic       frame_start,
    output logic [3:0] data_out,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [2:0] syndrome,
    output logic       err_flag,
    output logic       overrun,
    output logic       frame_abort
);

    rx_state_t  state, state_next;
    logic [2:0] count, count_next;
    logic [6:0] shreg, shreg_next;
    logic       abort_next;
    logic       load;
    logic [3:0] dec_data;
    logic [2:0] dec_syn;

    hamming74_correct #(.CORRECT(CORRECT)) u_correct (
        .codeword (shreg),
        .data     (dec_data),
        .syndrome (dec_syn)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            count <= '0;
            shreg <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
            shreg <= shreg_next;
        end
    end

    // Bits enter at the MSB and shift right, so bit 0 lands in shreg[0]
    // after the seventh accepted bit.
    always_comb begin
        state_next = state;
        count_next = count;
        shreg_next = shreg;
        abort_next = 1'b0;
        case (state)
            IDLE: begin
                if (bit_valid && frame_start) begin
                    state_next = SHIFT;
                    count_next = 3'd1;
                    shreg_next = {serial_in, 6'd0};
                end
            end
            SHIFT: begin
                if (bit_valid) begin
                    if (frame_start) begin
                        abort_next = 1'b1;
                        count_next = 3'd1;
                        shreg_next = {serial_in, 6'd0};
                    end else begin
                        shreg_next = {serial_in, shreg[6:1]};
                        count_next = count + 3'd1;
                        if (count == 3'd6) begin
                            state_next = DECODE;
                        end
                    end
                end
            end
            DECODE: begin
                if (bit_valid && frame_start) begin
                    state_next = SHIFT;
                    count_next = 3'd1;
                    shreg_next = {serial_in, 6'd0};
                end else begin
                    state_next = IDLE;
                    count_next = '0;
                end
            end
            default: begin
                state_next = IDLE;
                count_next = '0;
            end
        endcase
    end

    assign load = (state == DECODE) && (!out_valid || out_ready);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_out    <= '0;
            syndrome    <= '0;
            err_flag    <= 1'b0;
            out_valid   <= 1'b0;
            overrun     <= 1'b0;
            frame_abort <= 1'b0;
        end else begin
            overrun     <= (state == DECODE) && !load;
            frame_abort <= abort_next;
            if (load) begin
                data_out  <= dec_data;
                syndrome  <= dec_syn;
                err_flag  <= |dec_syn;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_hamming74_serial_rx.sv
// Randomized and directed bench for hamming74_serial_rx; runs a correcting
// and a detect-only instance side by side against a position-XOR model.
module tb_hamming74_serial_rx;

    logic clk = 1'b0;
    logic reset, serial_in, bit_valid, frame_start, out_ready;
    logic [3:0] data_out, data_out_nc;
    logic [2:0] syndrome, syndrome_nc;
    logic out_valid, out_valid_nc, err_flag, err_flag_nc;
    logic overrun, overrun_nc, frame_abort, frame_abort_nc;

    int pass_cnt = 0;
    int total = 0;
    int ov_cnt = 0;
    int ab_cnt = 0;
    logic [7:0] got_c[$];
    logic [7:0] got_n[$];

    always #5 clk = ~clk;

    hamming74_serial_rx #(.CORRECT(1)) dut (
        .clk(clk), .reset(reset), .serial_in(serial_in), .bit_valid(bit_valid),
        .frame_start(frame_start), .data_out(data_out), .out_valid(out_valid),
        .out_ready(out_ready), .syndrome(syndrome), .err_flag(err_flag),
        .overrun(overrun), .frame_abort(frame_abort)
    );

    hamming74_serial_rx #(.CORRECT(0)) dut_nc (
        .clk(clk), .reset(reset), .serial_in(serial_in), .bit_valid(bit_valid),
        .frame_start(frame_start), .data_out(data_out_nc), .out_valid(out_valid_nc),
        .out_ready(out_ready), .syndrome(syndrome_nc), .err_flag(err_flag_nc),
        .overrun(overrun_nc), .frame_abort(frame_abort_nc)
    );

    // Accepted words as {err, syndrome, data}, taken at the handshake edge.
    always @(posedge clk) begin
        if (out_valid && out_ready) begin
            got_c.push_back({err_flag, syndrome, data_out});
            got_n.push_back({err_flag_nc, syndrome_nc, data_out_nc});
        end
    end

    always @(negedge clk) begin
        if (overrun) ov_cnt++;
        if (frame_abort) ab_cnt++;
    end

    // Syndrome = XOR of the 1-based positions of all set bits.
    function automatic logic [7:0] model_decode(input logic [6:0] cw, input bit corr);
        int syn;
        logic [6:0] fixed;
        logic [2:0] s;
        syn = 0;
        for (int p = 1; p <= 7; p++) if (cw[p-1]) syn ^= p;
        fixed = cw;
        if (corr && syn != 0) fixed[syn-1] = ~fixed[syn-1];
        s = syn[2:0];
        return {(syn != 0), s, fixed[6], fixed[5], fixed[4], fixed[2]};
    endfunction

    function automatic logic [6:0] encode(input logic [3:0] d);
        logic [6:0] cw;
        int syn;
        cw = '0;
        cw[2] = d[0]; cw[4] = d[1]; cw[5] = d[2]; cw[6] = d[3];
        syn = 0;
        for (int p = 1; p <= 7; p++) if (cw[p-1]) syn ^= p;
        cw[0] = syn[0]; cw[1] = syn[1]; cw[3] = syn[2];
        return cw;
    endfunction

    task automatic idle(input int n);
        bit_valid = 1'b0;
        frame_start = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bits(input logic [6:0] cw, input int lo, input int hi, input bit gaps);
        for (int k = lo; k <= hi; k++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    bit_valid = 1'b0;
                    serial_in = 1'($urandom);
                    frame_start = 1'($urandom);
                    @(negedge clk);
                end
            end
            bit_valid = 1'b1;
            serial_in = cw[k];
            frame_start = (k == 0);
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        reset = 1'b0; bit_valid = 1'b0; frame_start = 1'b0; serial_in = 1'b0; out_ready = 1'b1;
        #3;
        total++;
        if ({data_out, syndrome, err_flag, out_valid, overrun, frame_abort} !== 11'd0)
            $display("FAIL reset_outputs: got %h expected 000",
                     {data_out, syndrome, err_flag, out_valid, overrun, frame_abort});
        else pass_cnt++;
        @(negedge clk);
        reset = 1'b1;
        idle(2);
        total++;
        if ({data_out, syndrome, err_flag, out_valid, overrun, frame_abort} !== 11'd0)
            $display("FAIL idle_after_reset: got %h expected 000",
                     {data_out, syndrome, err_flag, out_valid, overrun, frame_abort});
        else pass_cnt++;
    endtask

    task automatic test_clean;
        int n0;
        n0 = got_c.size();
        send_bits(7'h55, 0, 6, 1'b0);
        bit_valid = 1'b0; frame_start = 1'b0;
        total++;
        if (out_valid !== 1'b0) $display("FAIL latency_decode: got %b expected 0", out_valid);
        else pass_cnt++;
        @(negedge clk);
        total++;
        if ({out_valid, data_out, syndrome, err_flag} !== {1'b1, 4'b1011, 3'b000, 1'b0})
            $display("FAIL clean_word: got %h expected %h",
                     {out_valid, data_out, syndrome, err_flag}, {1'b1, 4'b1011, 3'b000, 1'b0});
        else pass_cnt++;
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0) $display("FAIL clean_consumed: got %b expected 0", out_valid);
        else pass_cnt++;
        total++;
        if (got_c.size() != n0 + 1) $display("FAIL clean_count: got %0d expected %0d", got_c.size(), n0 + 1);
        else pass_cnt++;
    endtask

    task automatic test_single_error;
        int n0;
        n0 = got_c.size();
        send_bits(7'b1000101, 0, 6, 1'b0);
        idle(3);
        total++;
        if (got_c.size() != n0 + 1) $display("FAIL err_count: got %0d expected %0d", got_c.size(), n0 + 1);
        else begin
            pass_cnt++;
            total++;
            if (got_c[n0] !== {1'b1, 3'b101, 4'b1011})
                $display("FAIL err_corrected: got %h expected %h", got_c[n0], {1'b1, 3'b101, 4'b1011});
            else pass_cnt++;
            total++;
            if (got_n[n0] !== {1'b1, 3'b101, 4'b1001})
                $display("FAIL err_detect_only: got %h expected %h", got_n[n0], {1'b1, 3'b101, 4'b1001});
            else pass_cnt++;
        end
    endtask

    task automatic test_gaps_back_to_back;
        int n0, ov0, ab0;
        n0 = got_c.size(); ov0 = ov_cnt; ab0 = ab_cnt;
        send_bits(7'h7F, 0, 6, 1'b1);
        send_bits(7'h00, 0, 6, 1'b0);
        idle(4);
        total++;
        if (got_c.size() != n0 + 2) $display("FAIL b2b_count: got %0d expected %0d", got_c.size(), n0 + 2);
        else begin
            pass_cnt++;
            total++;
            if (got_c[n0] !== 8'h0F) $display("FAIL b2b_word0: got %h expected 0f", got_c[n0]);
            else pass_cnt++;
            total++;
            if (got_c[n0+1] !== 8'h00) $display("FAIL b2b_word1: got %h expected 00", got_c[n0+1]);
            else pass_cnt++;
        end
        total++;
        if (ov_cnt != ov0 || ab_cnt != ab0)
            $display("FAIL b2b_pulses: got ov=%0d ab=%0d expected 0 0", ov_cnt - ov0, ab_cnt - ab0);
        else pass_cnt++;
    endtask

    task automatic test_abort;
        int n0, ab0;
        logic [6:0] junk;
        n0 = got_c.size(); ab0 = ab_cnt;
        junk = 7'($urandom);
        send_bits(junk, 0, 2, 1'b0);
        send_bits(7'h55, 0, 6, 1'b0);
        idle(3);
        total++;
        if (ab_cnt - ab0 != 1) $display("FAIL abort_pulse: got %0d cycles expected 1", ab_cnt - ab0);
        else pass_cnt++;
        total++;
        if (got_c.size() != n0 + 1) $display("FAIL abort_count: got %0d expected %0d", got_c.size(), n0 + 1);
        else begin
            pass_cnt++;
            total++;
            if (got_c[n0] !== 8'h0B) $display("FAIL abort_word: got %h expected 0b", got_c[n0]);
            else pass_cnt++;
        end
    endtask

    task automatic test_overrun;
        int n0, ov0;
        n0 = got_c.size(); ov0 = ov_cnt;
        out_ready = 1'b0;
        send_bits(7'h55, 0, 6, 1'b0);
        idle(2);
        send_bits(7'h7F, 0, 6, 1'b1);
        idle(3);
        total++;
        if (ov_cnt - ov0 != 1) $display("FAIL overrun_pulse: got %0d cycles expected 1", ov_cnt - ov0);
        else pass_cnt++;
        total++;
        if ({out_valid, data_out} !== 5'b1_1011)
            $display("FAIL overrun_held: got %b expected 11011", {out_valid, data_out});
        else pass_cnt++;
        out_ready = 1'b1;
        idle(3);
        total++;
        if (got_c.size() != n0 + 1) $display("FAIL overrun_count: got %0d expected %0d", got_c.size(), n0 + 1);
        else begin
            pass_cnt++;
            total++;
            if (got_c[n0] !== 8'h0B) $display("FAIL overrun_word: got %h expected 0b", got_c[n0]);
            else pass_cnt++;
        end
        total++;
        if (out_valid !== 1'b0) $display("FAIL overrun_drain: got %b expected 0", out_valid);
        else pass_cnt++;
    endtask

    task automatic test_random;
        for (int i = 0; i < 12; i++) begin
            int n0, pos;
            logic [3:0] d;
            logic [6:0] cw;
            logic [7:0] exp_c, exp_n;
            n0 = got_c.size();
            d = 4'($urandom);
            pos = $urandom_range(0, 7);
            cw = encode(d);
            if (pos != 0) cw[pos-1] = ~cw[pos-1];
            exp_c = model_decode(cw, 1'b1);
            exp_n = model_decode(cw, 1'b0);
            send_bits(cw, 0, 6, 1'($urandom));
            idle(3);
            total++;
            if (got_c.size() != n0 + 1 || got_c[n0] !== exp_c || got_n[n0] !== exp_n)
                $display("FAIL rand_word%0d: cw=%h got %h/%h expected %h/%h", i, cw,
                         (got_c.size() > n0) ? got_c[n0] : 8'hxx,
                         (got_n.size() > n0) ? got_n[n0] : 8'hxx, exp_c, exp_n);
            else pass_cnt++;
        end
    endtask

    task automatic test_back_to_back;
        logic [6:0] cws[4];
        int n0;
        n0 = got_c.size();
        for (int i = 0; i < 4; i++) begin
            int pos;
            cws[i] = encode(4'($urandom));
            pos = $urandom_range(0, 7);
            if (pos != 0) cws[i][pos-1] = ~cws[i][pos-1];
        end
        for (int i = 0; i < 4; i++) send_bits(cws[i], 0, 6, 1'b0);
        idle(4);
        total++;
        if (got_c.size() != n0 + 4) $display("FAIL b2b_rand_count: got %0d expected %0d", got_c.size(), n0 + 4);
        else begin
            pass_cnt++;
            for (int i = 0; i < 4; i++) begin
                total++;
                if (got_c[n0+i] !== model_decode(cws[i], 1'b1))
                    $display("FAIL b2b_rand_word%0d: got %h expected %h", i, got_c[n0+i],
                             model_decode(cws[i], 1'b1));
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_reset_midframe;
        int n0;
        n0 = got_c.size();
        send_bits(7'h55, 0, 2, 1'b0);
        #2 reset = 1'b0;
        #1;
        total++;
        if ({data_out, syndrome, err_flag, out_valid, overrun, frame_abort} !== 11'd0)
            $display("FAIL midframe_reset: got %h expected 000",
                     {data_out, syndrome, err_flag, out_valid, overrun, frame_abort});
        else pass_cnt++;
        @(negedge clk);
        reset = 1'b1;
        send_bits(7'h55, 3, 6, 1'b0);
        idle(3);
        total++;
        if (got_c.size() != n0) $display("FAIL midframe_discard: got %0d words expected 0", got_c.size() - n0);
        else pass_cnt++;

        out_ready = 1'b0;
        send_bits(7'b1000101, 0, 6, 1'b0);
        idle(2);
        total++;
        if (out_valid !== 1'b1) $display("FAIL held_before_reset: got %b expected 1", out_valid);
        else pass_cnt++;
        #2 reset = 1'b0;
        #1;
        total++;
        if ({data_out, syndrome, err_flag, out_valid} !== 9'd0)
            $display("FAIL held_async_clear: got %h expected 000", {data_out, syndrome, err_flag, out_valid});
        else pass_cnt++;
        @(negedge clk);
        reset = 1'b1;
        out_ready = 1'b1;
        idle(2);
        send_bits(7'h55, 0, 6, 1'b0);
        idle(3);
        total++;
        if (got_c.size() != n0 + 1) $display("FAIL post_reset_count: got %0d expected %0d", got_c.size(), n0 + 1);
        else begin
            pass_cnt++;
            total++;
            if (got_c[n0] !== 8'h0B) $display("FAIL post_reset_word: got %h expected 0b", got_c[n0]);
            else pass_cnt++;
        end
    endtask

    initial begin
        test_reset;
        test_clean;
        test_single_error;
        test_gaps_back_to_back;
        test_abort;
        test_overrun;
        test_random;
        test_back_to_back;
        test_reset_midframe;
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
